// File: rtl/usb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// usb_bridge_pkg
// Shared definitions for the Wishbone-to-USB register bridge:
//   - bridge_state_t : bridge FSM encoding (IDLE, REQ, RESP, GAP)
//   - ERR_RDATA_DEFAULT : read data returned on an error or timeout
//   - RANGE_MSB/RANGE_LSB : byte-address bits that must be zero for an access
//     to reach the register block
//   - addr_in_range() : range check on a Wishbone byte address
// ---------------------------------------------------------------------------
package usb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } bridge_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_0BAD;

  localparam int WB_ADR_W  = 13;
  localparam int RANGE_MSB = 12;
  localparam int RANGE_LSB = 11;

  function automatic logic addr_in_range(input logic [WB_ADR_W-1:0] adr);
    return (adr[RANGE_MSB:RANGE_LSB] == '0);
  endfunction

endpackage

// File: rtl/usb_bridge_tmo_cnt.sv
// ---------------------------------------------------------------------------
// usb_bridge_tmo_cnt
// Hang-timeout counter for the register bridge. Cleared when a downstream
// request starts, advanced once per cycle the request is outstanding, and
// flags expiry on the cycle it sits at TIMEOUT_CYC-1.
// Ports:
//   app_clk  in  : clock
//   reset    in  : synchronous active-high reset (counter to 0)
//   clr      in  : clear counter (request being launched)
//   inc      in  : request outstanding this cycle
//   expire   out : outstanding request has used up its cycle budget
// ---------------------------------------------------------------------------
module usb_bridge_tmo_cnt #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic app_clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt;

  always_ff @(posedge app_clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = inc && (cnt == TMO_LAST);

endmodule

// File: rtl/usb_wb_reg_bridge.sv
// ---------------------------------------------------------------------------
// usb_wb_reg_bridge
// Wishbone B4 classic slave in front of the USB host/device register block.
// Each Wishbone cycle is captured, presented on the reg_* request bus and
// held stable until reg_ack, then answered with a one-cycle wbs_ack_o (or
// wbs_err_o for out-of-range addresses / timeout). A GAP cycle follows every
// response so reg_cs is always low between two requests.
//
// Optional build macro: USB_WB_BRIDGE_TIMEOUT_EN
//   defined   : a request without reg_ack for TIMEOUT_CYC cycles is ended
//               with wbs_err_o and wbs_dat_o = ERR_RDATA
//   undefined : the bridge waits for reg_ack indefinitely
//
// Ports:
//   app_clk, reset                 : clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/adr_i/we_i/
//   wbs_dat_i/sel_i                : Wishbone request (byte address)
//   wbs_dat_o/ack_o/err_o          : Wishbone response
//   reg_cs/wr/addr/wdata/be        : downstream register request
//   reg_rdata, reg_ack             : downstream response
//   busy_o                         : bridge not in IDLE
// ---------------------------------------------------------------------------
module usb_wb_reg_bridge
  import usb_bridge_pkg::*;
#(
  parameter int          AW          = 11,
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic                app_clk,
  input  logic                reset,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic [WB_ADR_W-1:0] wbs_adr_i,
  input  logic                wbs_we_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [3:0]          wbs_sel_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic                reg_cs,
  output logic                reg_wr,
  output logic [AW-1:0]       reg_addr,
  output logic [31:0]         reg_wdata,
  output logic [3:0]          reg_be,
  input  logic [31:0]         reg_rdata,
  input  logic                reg_ack,
  output logic                busy_o
);

  if (TIMEOUT_CYC < 4 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("usb_wb_reg_bridge: TIMEOUT_CYC must be within 4..65535");
  end

  bridge_state_t state, state_nxt;

  logic          req_start;   // in-range request accepted, launch downstream
  logic          req_bad;     // out-of-range request, answer with err
  logic          req_done;    // downstream access finished (ack or timeout)
  logic          in_req;
  logic          tmo_expire;
  logic          abort_q;     // master dropped cyc while the request was out
  logic          master_alive;

  logic [AW-1:0] cap_addr;
  logic          cap_wr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;

  logic [31:0]   dat_q;
  logic          ack_q;
  logic          err_q;

  assign in_req = (state == REQ);

`ifdef USB_WB_BRIDGE_TIMEOUT_EN
  usb_bridge_tmo_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .app_clk (app_clk),
    .reset   (reset),
    .clr     (req_start),
    .inc     (in_req),
    .expire  (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_start = 1'b0;
    req_bad   = 1'b0;
    req_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (addr_in_range(wbs_adr_i)) begin
            state_nxt = REQ;
            req_start = 1'b1;
          end else begin
            state_nxt = RESP;
            req_bad   = 1'b1;
          end
        end
      end
      REQ: begin
        if (reg_ack || tmo_expire) begin
          state_nxt = RESP;
          req_done  = 1'b1;
        end
      end
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The response is only returned if the master is still in its cycle and
  // never left it while the downstream access was outstanding.
  assign master_alive = wbs_cyc_i && !abort_q;

  always_ff @(posedge app_clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      if (req_start) begin
        abort_q <= 1'b0;
      end else if (in_req && !wbs_cyc_i) begin
        abort_q <= 1'b1;
      end

      if (req_bad) begin
        err_q <= 1'b1;
        dat_q <= ERR_RDATA;
      end

      // reg_ack has priority over a timeout expiring in the same cycle.
      if (req_done) begin
        if (reg_ack) begin
          ack_q <= master_alive;
          if (!cap_wr) begin
            dat_q <= reg_rdata;
          end
        end else begin
          err_q <= master_alive;
          dat_q <= ERR_RDATA;
        end
      end

      if (state == RESP) begin
        dat_q <= '0;
      end
    end
  end

  // Request payload: only qualified by state, so it needs no reset.
  always_ff @(posedge app_clk) begin
    if (state == IDLE && wbs_cyc_i && wbs_stb_i) begin
      cap_addr  <= wbs_adr_i[AW-1:0];
      cap_wr    <= wbs_we_i;
      cap_wdata <= wbs_dat_i;
      cap_be    <= wbs_sel_i;
    end
  end

  // Downstream bus is driven only in REQ and is zero elsewhere, so the
  // register block sees a clean, constant request for the whole access.
  assign reg_cs    = in_req;
  assign reg_wr    = in_req && cap_wr;
  assign reg_addr  = in_req ? cap_addr  : '0;
  assign reg_wdata = in_req ? cap_wdata : '0;
  assign reg_be    = in_req ? cap_be    : '0;

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_usb_wb_reg_bridge.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_usb_wb_reg_bridge
// Directed scoreboard bench for usb_wb_reg_bridge. Stimulus tasks push the
// expected Wishbone response into a queue; a monitor pops and compares on
// every wbs_ack_o/wbs_err_o. A downstream responder model drives reg_ack and
// checks that the request bus matches the issued transaction while reg_cs is
// high. Timeout cases are built only with USB_WB_BRIDGE_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_usb_wb_reg_bridge;

  localparam int TMO = 8;

  logic        app_clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [12:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic        reg_cs, reg_wr;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_ack   = 1'b0;
  logic        busy_o;

  always #5 app_clk = ~app_clk;

  usb_wb_reg_bridge #(
    .AW          (11),
    .TIMEOUT_CYC (TMO),
    .ERR_RDATA   (32'hDEAD_0BAD)
  ) dut (
    .app_clk   (app_clk),
    .reset     (reset),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy_o    (busy_o)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n_resp = 0;
  int    cs_total = 0;

  // responder configuration, written by stimulus
  int          ack_delay = -1;
  logic [31:0] rsp_rdata = 32'h0;
  bit          spurious  = 1'b0;
  logic [10:0] exp_addr  = '0;
  logic        exp_wr    = 1'b0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be    = '0;
  int          cs_idx    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge app_clk);
      #1;
    end
  endtask

  // Downstream register block model.
  always @(negedge app_clk) begin
    if (reg_cs) begin
      chk("req_bus", {reg_wr, reg_be, reg_addr, reg_wdata},
                     {exp_wr, exp_be, exp_addr, exp_wdata});
      reg_ack   = (cs_idx == ack_delay);
      reg_rdata = (cs_idx == ack_delay) ? rsp_rdata : 32'h0;
      cs_idx++;
      cs_total++;
    end else begin
      cs_idx    = 0;
      reg_ack   = spurious;
      reg_rdata = 32'h5555_AAAA;
    end
  end

  // Response monitor.
  always @(negedge app_clk) begin
    resp_t e;
    if (wbs_ack_o || wbs_err_o) begin
      n_resp++;
      chk("ack_err_exclusive", {63'b0, wbs_ack_o && wbs_err_o}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=ack%0b_err%0b required=none", wbs_ack_o, wbs_err_o);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", {62'b0, wbs_ack_o, wbs_err_o}, e.is_err ? 64'd1 : 64'd2);
        chk("resp_dat", {32'b0, wbs_dat_o}, {32'b0, e.dat});
      end
    end
  end

  // One Wishbone transaction. Caller is at posedge+1.
  // lat_min/lat_max: cycles from request sample to ack/err (ignored if aborted)
  task automatic run_txn(input string tag, input logic [12:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int delay, input logic [31:0] rdata,
                         input bit exp_err, input logic [31:0] exp_dat,
                         input int lat_min, input int lat_max,
                         input int abort_at, input int exp_cs);
    int  n0, cs0, lat;
    bit  done;
    ack_delay = delay;
    rsp_rdata = rdata;
    exp_addr  = adr[10:0];
    exp_wr    = we;
    exp_wdata = dat;
    exp_be    = sel;
    if (abort_at < 0) exp_q.push_back('{is_err: exp_err, dat: exp_dat});
    n0   = n_resp;
    cs0  = cs_total;
    lat  = -1;
    done = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int i = 1; i <= 60 && !done; i++) begin
      tick(1);
      if (i == abort_at) begin
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end
      if ((wbs_ack_o || wbs_err_o) && lat < 0) begin
        lat = i;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end else if (lat > 0 && i == lat + 1) begin
        chk({tag, "_gap_cs"}, {63'b0, reg_cs}, 64'd0);
        chk({tag, "_gap_dat"}, {32'b0, wbs_dat_o}, 64'd0);
      end
      if (!busy_o) done = 1'b1;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", tag);
    end
    chk({tag, "_cs_cycles"}, 64'(cs_total - cs0), 64'(exp_cs));
    chk({tag, "_resp_count"}, 64'(n_resp - n0), (abort_at < 0) ? 64'd1 : 64'd0);
    if (abort_at < 0)
      chk({tag, "_latency_ok"}, {63'b0, (lat >= lat_min && lat <= lat_max)}, 64'd1);
    chk({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n0;
    reset     = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_adr_i = '0;
    wbs_we_i  = 1'b0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    tick(3);
    chk("rst_outputs", {reg_cs, reg_wr, reg_be, reg_addr, wbs_ack_o, wbs_err_o, busy_o},
                       64'd0);
    chk("rst_dat", {32'b0, wbs_dat_o}, 64'd0);
    chk("rst_wdata", {32'b0, reg_wdata}, 64'd0);
    reset = 1'b0;
    tick(1);

    //      tag      adr       we    dat            sel   dly rdata         err  exp_dat       lmin lmax abort cs
    run_txn("wr044", 13'h044, 1'b1, 32'h1234_5678, 4'hF, 2, 32'h0,        1'b0, 32'h0,         4, 4, -1, 3);
    run_txn("rd048", 13'h048, 1'b0, 32'h0,         4'hF, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3, 3, -1, 2);
    run_txn("wr7fc", 13'h7FC, 1'b1, 32'hA5A5_0F0F, 4'h3, 0, 32'h0,        1'b0, 32'h0,         2, 2, -1, 1);
    run_txn("oor800", 13'h0800, 1'b1, 32'h1111_2222, 4'hF, 0, 32'h0,      1'b1, 32'hDEAD_0BAD, 1, 2, -1, 0);
    run_txn("oor1000", 13'h1000, 1'b0, 32'h0,      4'hF, 0, 32'h0,        1'b1, 32'hDEAD_0BAD, 1, 2, -1, 0);

    // reg_ack while idle is ignored
    n0 = n_resp;
    spurious = 1'b1;
    tick(2);
    spurious = 1'b0;
    tick(2);
    chk("spurious_busy", {63'b0, busy_o}, 64'd0);
    chk("spurious_resp", 64'(n_resp - n0), 64'd0);

    // master abort while REQ outstanding: access completes, no response
    run_txn("abort", 13'h010, 1'b0, 32'h0, 4'hF, 3, 32'h7777_8888, 1'b0, 32'h0, 0, 0, 2, 4);
    chk("abort_busy", {63'b0, busy_o}, 64'd0);

    // reset asserted while REQ outstanding
    n0 = n_resp;
    ack_delay = -1;
    exp_addr  = 11'h020;
    exp_wr    = 1'b0;
    exp_wdata = 32'h0;
    exp_be    = 4'hF;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = 13'h020;
    wbs_we_i  = 1'b0;
    wbs_dat_i = 32'h0;
    wbs_sel_i = 4'hF;
    tick(3);
    chk("rstreq_cs_before", {63'b0, reg_cs}, 64'd1);
    reset     = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    tick(1);
    chk("rstreq_state", {reg_cs, busy_o, wbs_ack_o, wbs_err_o}, 64'd0);
    reset = 1'b0;
    tick(3);
    chk("rstreq_no_resp", 64'(n_resp - n0), 64'd0);
    chk("rstreq_idle", {63'b0, busy_o}, 64'd0);

    run_txn("post_rst", 13'h0C0, 1'b1, 32'hDEAD_BEEF, 4'h9, 1, 32'h0, 1'b0, 32'h0, 3, 3, -1, 2);

`ifdef USB_WB_BRIDGE_TIMEOUT_EN
    run_txn("tmo_hang", 13'h050, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b1, 32'hDEAD_0BAD,
            TMO + 1, TMO + 1, -1, TMO);
    run_txn("tmo_next", 13'h054, 1'b0, 32'h0, 4'hF, 1, 32'h2468_ACE0, 1'b0, 32'h2468_ACE0,
            3, 3, -1, 2);
    run_txn("tmo_race", 13'h058, 1'b0, 32'h0, 4'hF, TMO - 1, 32'h1357_9BDF, 1'b0,
            32'h1357_9BDF, TMO + 1, TMO + 1, -1, TMO);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
